// File: rtl/nested_loop_counter_pkg.sv
// Shared constants for the nested loop counter.
//   NLC_IDLE / NLC_RUN : controller state encodings (1-bit, legacy compatible)
//   NLC_MAX_LEVELS     : largest supported nesting depth
package nested_loop_counter_pkg;
   localparam logic [0:0] NLC_IDLE       = 1'b0;
   localparam logic [0:0] NLC_RUN        = 1'b1;
   localparam int         NLC_MAX_LEVELS = 8;
endpackage : nested_loop_counter_pkg

// File: rtl/nested_loop_counter_if.sv
// Control/status bundle of the nested loop counter.
//   start, clr, inc, bound_i      : driven by the controlling agent (master)
//   idx_o, wrap_o, busy_o, done_o : driven by the counter (slave)
//   last_o                        : only with NESTED_LOOP_LAST_EN defined
interface nested_loop_counter_if #(
   parameter int LEVELS = 3,
   parameter int WIDTH  = 8
);
   logic                      start;
   logic                      clr;
   logic                      inc;
   logic [LEVELS*WIDTH-1:0]   bound_i;
   logic [LEVELS*WIDTH-1:0]   idx_o;
   logic [LEVELS-1:0]         wrap_o;
   logic                      busy_o;
   logic                      done_o;
`ifdef NESTED_LOOP_LAST_EN
   logic [LEVELS-1:0]         last_o;
`endif

   modport master (
      output start, clr, inc, bound_i,
`ifdef NESTED_LOOP_LAST_EN
      input  last_o,
`endif
      input  idx_o, wrap_o, busy_o, done_o
   );

   modport slave (
      input  start, clr, inc, bound_i,
`ifdef NESTED_LOOP_LAST_EN
      output last_o,
`endif
      output idx_o, wrap_o, busy_o, done_o
   );
endinterface : nested_loop_counter_if

// File: rtl/nested_loop_counter_level.sv
// One level of the nested loop counter: holds the latched bound and the index.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : latch bound_in (0 maps to DEF_MAX) and zero the index
//   bound_in   : runtime bound for this level
//   clear      : zero the index, bound kept (abort / sequence end)
//   step       : advance this level (accepted inc with carry reaching here)
//   idx_o      : current index (registered)
//   at_max_o   : index sits on bound-1, i.e. the next step wraps this level
module nested_loop_counter_level #(
   parameter int WIDTH   = 8,
   parameter int DEF_MAX = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] bound_in,
   input  logic             clear,
   input  logic             step,
   output logic [WIDTH-1:0] idx_o,
   output logic             at_max_o
);
   localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1'b1);
   localparam logic [WIDTH-1:0] DEF_MAX_W = WIDTH'(DEF_MAX);

   logic [WIDTH-1:0] idx_r;
   logic [WIDTH-1:0] bnd_r;

   // bnd_r is never 0 once loaded, so bnd_r-1 is a valid last index
   assign at_max_o = (idx_r == (bnd_r - ONE_W));
   assign idx_o    = idx_r;

   // Bound latch and index update; clear has priority over load and step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r <= ZERO_W;
         bnd_r <= ZERO_W;
      end else if (clear) begin
         idx_r <= ZERO_W;
      end else if (load) begin
         bnd_r <= (bound_in == ZERO_W) ? DEF_MAX_W : bound_in;
         idx_r <= ZERO_W;
      end else if (step) begin
         idx_r <= at_max_o ? ZERO_W : (idx_r + ONE_W);
      end else begin
         idx_r <= idx_r;
      end
   end
endmodule : nested_loop_counter_level

// File: rtl/nested_loop_counter.sv
// Nested loop index generator (level 0 innermost) with start/abort control,
// per-level wrap strobes and a one-cycle completion pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : nested_loop_counter_if.slave
//                start/clr/inc/bound_i in; idx_o/busy_o/done_o registered out;
//                wrap_o combinational from the accepted inc.
// Optional: NESTED_LOOP_LAST_EN adds last_o (per-level "on last index" flag).
module nested_loop_counter
   import nested_loop_counter_pkg::*;
#(
   parameter int LEVELS  = 3,
   parameter int WIDTH   = 8,
   parameter int DEF_MAX = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   nested_loop_counter_if.slave bus
);
   logic [0:0]              state_r;
   logic                    done_r;
   logic                    busy_s;
   logic                    accept_s;
   logic                    load_s;
   logic [LEVELS:0]         carry_s;
   logic [LEVELS-1:0]       at_max_s;
   logic [LEVELS*WIDTH-1:0] idx_all_s;

   assign busy_s   = (state_r == NLC_RUN);
   assign accept_s = busy_s & bus.inc & ~bus.clr;
   assign load_s   = ~busy_s & bus.start & ~bus.clr;
   assign carry_s[0] = 1'b1;

   for (genvar l = 0; l < LEVELS; l++) begin : g_level
      // A level advances only when every inner level is on its last index
      assign carry_s[l+1] = carry_s[l] & at_max_s[l];

      nested_loop_counter_level #(
         .WIDTH   (WIDTH),
         .DEF_MAX (DEF_MAX)
      ) u_level (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (load_s),
         .bound_in (bus.bound_i[l*WIDTH +: WIDTH]),
         .clear    (bus.clr),
         .step     (accept_s & carry_s[l]),
         .idx_o    (idx_all_s[l*WIDTH +: WIDTH]),
         .at_max_o (at_max_s[l])
      );
   end

   // Sequencer: IDLE/RUN and the completion pulse; clr aborts silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= NLC_IDLE;
         done_r  <= 1'b0;
      end else if (bus.clr) begin
         state_r <= NLC_IDLE;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            NLC_IDLE: begin
               state_r <= bus.start ? NLC_RUN : NLC_IDLE;
               done_r  <= 1'b0;
            end
            NLC_RUN: begin
               // Carry out of the outermost level means the last tuple was consumed
               if (accept_s & carry_s[LEVELS]) begin
                  state_r <= NLC_IDLE;
                  done_r  <= 1'b1;
               end else begin
                  state_r <= NLC_RUN;
                  done_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= NLC_IDLE;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.idx_o  = idx_all_s;
   assign bus.busy_o = busy_s;
   assign bus.done_o = done_r;
   assign bus.wrap_o = {LEVELS{accept_s}} & carry_s[LEVELS:1];
`ifdef NESTED_LOOP_LAST_EN
   assign bus.last_o = {LEVELS{busy_s}} & at_max_s;
`endif
endmodule : nested_loop_counter

// File: tb/tb_nested_loop_counter.sv
// Self-checking bench for nested_loop_counter: directed scenarios followed by
// randomized control traffic, checked against a linear-count reference model.
module tb_nested_loop_counter;
   localparam int LEVELS  = 3;
   localparam int WIDTH   = 8;
   localparam int DEF_MAX = 8;
   localparam int VW      = LEVELS*WIDTH;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   nested_loop_counter_if #(.LEVELS(LEVELS), .WIDTH(WIDTH)) bus ();

   nested_loop_counter #(
      .LEVELS  (LEVELS),
      .WIDTH   (WIDTH),
      .DEF_MAX (DEF_MAX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model: a sequence is a single linear count m_n in 0..product-1;
   // the index tuple is its mixed-radix decomposition over the latched bounds.
   bit m_busy = 1'b0;
   bit m_done = 1'b0;
   int m_n    = 0;
   int m_bnd [LEVELS];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int total();
      int p = 1;
      for (int l = 0; l < LEVELS; l++) p = p * m_bnd[l];
      return p;
   endfunction

   function automatic logic [VW-1:0] exp_idx();
      logic [VW-1:0] v = '0;
      int div = 1;
      if (m_busy) begin
         for (int l = 0; l < LEVELS; l++) begin
            v[l*WIDTH +: WIDTH] = WIDTH'((m_n / div) % m_bnd[l]);
            div = div * m_bnd[l];
         end
      end
      return v;
   endfunction

   function automatic logic [LEVELS-1:0] exp_last();
      logic [LEVELS-1:0] v = '0;
      int div = 1;
      if (m_busy) begin
         for (int l = 0; l < LEVELS; l++) begin
            v[l] = (((m_n / div) % m_bnd[l]) == (m_bnd[l] - 1));
            div = div * m_bnd[l];
         end
      end
      return v;
   endfunction

   // Level l wraps when the next count is a multiple of the product of bounds 0..l
   function automatic logic [LEVELS-1:0] exp_wrap(input bit acc);
      logic [LEVELS-1:0] v = '0;
      int prod = 1;
      for (int l = 0; l < LEVELS; l++) begin
         prod = prod * m_bnd[l];
         v[l] = acc && (((m_n + 1) % prod) == 0);
      end
      return v;
   endfunction

   task automatic check_outputs(input string where);
      check_val({where, "_idx"},  32'(bus.idx_o),  32'(exp_idx()));
      check_val({where, "_busy"}, 32'(bus.busy_o), 32'(m_busy));
      check_val({where, "_done"}, 32'(bus.done_o), 32'(m_done));
`ifdef NESTED_LOOP_LAST_EN
      check_val({where, "_last"}, 32'(bus.last_o), 32'(exp_last()));
`endif
   endtask

   // One clock: drive at posedge+1, check wrap_o before the edge, model, check after
   task automatic cycle(input bit st, input bit cl, input bit in, input logic [VW-1:0] bnd);
      bit acc;
      logic [WIDTH-1:0] f;
      bus.start   = st;
      bus.clr     = cl;
      bus.inc     = in;
      bus.bound_i = bnd;
      #1;
      acc = m_busy && in && !cl;
      check_val("wrap", 32'(bus.wrap_o), 32'(exp_wrap(acc)));
      m_done = 1'b0;
      if (cl) begin
         m_busy = 1'b0;
         m_n    = 0;
      end else if (!m_busy && st) begin
         for (int l = 0; l < LEVELS; l++) begin
            f = bnd[l*WIDTH +: WIDTH];
            m_bnd[l] = (f == '0) ? DEF_MAX : int'(f);
         end
         m_n    = 0;
         m_busy = 1'b1;
      end else if (acc) begin
         m_n++;
         if (m_n == total()) begin
            m_n    = 0;
            m_busy = 1'b0;
            m_done = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check_outputs("cyc");
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic async_reset();
      bus.start = 1'b0;
      bus.clr   = 1'b0;
      bus.inc   = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_n    = 0;
      check_outputs("arst");
      check_val("arst_wrap", 32'(bus.wrap_o), 32'd0);
      bus.inc = 1'b0;
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VW-1:0] rand_bounds();
      logic [VW-1:0] b;
      for (int l = 0; l < LEVELS; l++) b[l*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 5));
      return b;
   endfunction

   initial begin
      logic [VW-1:0] b234;
      logic [VW-1:0] b103;
      b234 = {8'd4, 8'd3, 8'd2};
      b103 = {8'd3, 8'd0, 8'd1};
      for (int l = 0; l < LEVELS; l++) m_bnd[l] = 1;
      bus.start   = 1'b0;
      bus.clr     = 1'b0;
      bus.inc     = 1'b0;
      bus.bound_i = '0;

      // Reset values
      #12;
      check_outputs("reset");
      check_val("reset_wrap", 32'(bus.wrap_o), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full 2x3x4 walk, done on the cycle after the 24th inc
      cycle(1'b1, 1'b0, 1'b0, b234);
      for (int i = 0; i < 24; i++) begin
         if (i == 19) begin
            bus.inc = 1'b1;
            #1;
            check_val("wrap_103", 32'(bus.wrap_o), 32'd1);
         end
         if (i == 23) begin
            bus.inc = 1'b1;
            #1;
            check_val("wrap_123", 32'(bus.wrap_o), 32'd7);
         end
         cycle(1'b0, 1'b0, 1'b1, b234);
      end
      check_val("done_24", 32'(bus.done_o), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, b234);
      check_val("done_pulse", 32'(bus.done_o), 32'd0);

      // Bound 1 on level 0, default bound on level 1
      cycle(1'b1, 1'b0, 1'b0, b103);
      for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, 1'b1, b103);

      // Abort at (0,1,2) with inc asserted
      cycle(1'b1, 1'b0, 1'b0, b234);
      for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 1'b1, b234);
      check_val("pre_clr_idx", 32'(bus.idx_o), 32'h020100);
      cycle(1'b0, 1'b1, 1'b1, b234);
      cycle(1'b0, 1'b0, 1'b1, b234);
      cycle(1'b1, 1'b1, 1'b0, b234);

      // start while running, bound_i churn, inc while idle
      cycle(1'b1, 1'b0, 1'b0, b234);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, rand_bounds());

      // Async reset mid-sequence
      async_reset();
      cycle(1'b0, 1'b0, 1'b1, b234);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if (i % 900 == 450) async_reset();
         cycle($urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0,
               $urandom_range(0, 3) != 0, rand_bounds());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule : tb_nested_loop_counter
